pcie_os_detect: RTL and testbench

- Per-lane ordered-set detector for the 2.5/5.0 GT/s 8b/10b receive path. It sits after the 10b/8b decoder and before LTSSM/elastic-buffer logic.
- Tracks the K-symbol stream on each of NUM_LANES lanes and recognises SKP, EIOS and FTS ordered sets. Malformed sequences are flagged.
- Provides a cross-lane "EIOS seen on all active lanes" event that tolerates lane-to-lane skew.

---
 rtl/pcie_os_detect.sv | 161 ++++++++++++++++
 tb/tb_pcie_os_detect.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_os_detect.sv
// Per-lane ordered-set detector for the 8b/10b receive path (SKP, EIOS, FTS),
// plus a skew-tolerant "EIOS seen on all active lanes" aggregate event.
module pcie_os_detect #(
   parameter int NUM_LANES = 4,
   parameter int MAX_SKP   = 5,
   parameter int CNT_W     = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_LANES*8-1:0]     sym_data,
   input  logic [NUM_LANES-1:0]       sym_k,
   input  logic [NUM_LANES-1:0]       sym_valid,
   input  logic [NUM_LANES-1:0]       lane_mask,
   input  logic                       clr,
   output logic [NUM_LANES-1:0]       skp_det,
   output logic [NUM_LANES*CNT_W-1:0] skp_cnt,
   output logic [NUM_LANES-1:0]       eios_det,
   output logic [NUM_LANES-1:0]       fts_det,
   output logic [NUM_LANES-1:0]       os_err,
   output logic [NUM_LANES-1:0]       eios_seen,
   output logic                       eios_all
);

   localparam logic [7:0] SYM_COM = 8'hBC;
   localparam logic [7:0] SYM_SKP = 8'h1C;
   localparam logic [7:0] SYM_FTS = 8'h3C;
   localparam logic [7:0] SYM_IDL = 8'h7C;
   localparam logic [2:0] MAX_SKP_C = 3'(MAX_SKP);
   // cnt value at which the next matching IDL/FTS is the 4th symbol of the OS
   localparam logic [2:0] OS_LAST_C = 3'd2;

   typedef enum logic [2:0] {ST_IDLE, ST_COM, ST_SKP, ST_IDL, ST_FTS} lane_state_e;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [7:0]       data;
      logic             is_com, is_skp, is_idl, is_fts, is_run;
      logic             restart;
      lane_state_e      st_q, st_d;
      logic [2:0]       cnt_q, cnt_d;
      logic             skp_det_q, skp_det_d;
      logic             eios_det_q, eios_det_d;
      logic             fts_det_q, fts_det_d;
      logic             os_err_q, os_err_d;
      logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;

      assign data   = sym_data[8*i +: 8];
      assign is_com = sym_k[i] && (data == SYM_COM);
      assign is_skp = sym_k[i] && (data == SYM_SKP);
      assign is_idl = sym_k[i] && (data == SYM_IDL);
      assign is_fts = sym_k[i] && (data == SYM_FTS);
      assign is_run = (st_q == ST_IDL) ? is_idl : is_fts;

      always_comb begin
         // NOTE: every combinational output gets a default first so no path infers a latch.
         st_d       = st_q;
         cnt_d      = cnt_q;
         skp_cnt_d  = skp_cnt_q;
         skp_det_d  = 1'b0;
         eios_det_d = 1'b0;
         fts_det_d  = 1'b0;
         os_err_d   = 1'b0;
         restart    = 1'b0;
         if (sym_valid[i]) begin
            unique case (st_q)
               ST_IDLE: restart = 1'b1;
               ST_COM: begin
                  cnt_d = 3'd1;
                  if (is_skp)      st_d = ST_SKP;
                  else if (is_idl) st_d = ST_IDL;
                  else if (is_fts) st_d = ST_FTS;
                  else begin
                     os_err_d = 1'b1;
                     restart  = 1'b1;
                  end
               end
               ST_SKP: begin
                  if (is_skp) begin
                     if (cnt_q < MAX_SKP_C) cnt_d = cnt_q + 3'd1;
                     else begin
                        os_err_d = 1'b1;
                        st_d     = ST_IDLE;
                     end
                  end else begin
                     skp_det_d = 1'b1;
                     skp_cnt_d = CNT_W'(cnt_q);
                     restart   = 1'b1;
                  end
               end
               ST_IDL, ST_FTS: begin
                  if (is_run) begin
                     if (cnt_q == OS_LAST_C) begin
                        eios_det_d = (st_q == ST_IDL);
                        fts_det_d  = (st_q == ST_FTS);
                        st_d       = ST_IDLE;
                     end else begin
                        cnt_d = cnt_q + 3'd1;
                     end
                  end else begin
                     os_err_d = 1'b1;
                     restart  = 1'b1;
                  end
               end
               default: st_d = ST_IDLE;
            endcase
            // the symbol that ends or breaks an OS is re-judged as if seen in IDLE
            if (restart) st_d = is_com ? ST_COM : ST_IDLE;
         end
      end

      always_ff @(posedge clk) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         if (rst) begin
            st_q       <= ST_IDLE;
            cnt_q      <= '0;
            skp_cnt_q  <= '0;
            skp_det_q  <= 1'b0;
            eios_det_q <= 1'b0;
            fts_det_q  <= 1'b0;
            os_err_q   <= 1'b0;
         end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            skp_cnt_q  <= skp_cnt_d;
            skp_det_q  <= skp_det_d;
            eios_det_q <= eios_det_d;
            fts_det_q  <= fts_det_d;
            os_err_q   <= os_err_d;
         end
      end

      assign skp_det[i]                 = skp_det_q;
      assign skp_cnt[CNT_W*i +: CNT_W]  = skp_cnt_q;
      assign eios_det[i]                = eios_det_q;
      assign fts_det[i]                 = fts_det_q;
      assign os_err[i]                  = os_err_q;
   end

   logic [NUM_LANES-1:0] eios_seen_q, eios_seen_d;
   logic                 eios_all_q, eios_all_d;

   always_comb begin
      eios_all_d  = (lane_mask != '0) && ((eios_seen_q & lane_mask) == lane_mask);
      eios_seen_d = (clr || eios_all_d) ? '0 : eios_seen_q;
      // a fresh EIOS always survives a simultaneous clear
      eios_seen_d = eios_seen_d | eios_det;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         eios_seen_q <= '0;
         eios_all_q  <= 1'b0;
      end else begin
         eios_seen_q <= eios_seen_d;
         eios_all_q  <= eios_all_d;
      end
   end

   assign eios_seen = eios_seen_q;
   assign eios_all  = eios_all_q;

endmodule

// File: tb/tb_pcie_os_detect.sv
// Self-checking bench for pcie_os_detect: directed scenarios plus randomized
// symbol streams checked against an ordered-set-level reference model.
module tb_pcie_os_detect;

   localparam int NL      = 4;
   localparam int MAX_SKP = 5;
   localparam int CNT_W   = 3;

   localparam logic [7:0] K_COM = 8'hBC;
   localparam logic [7:0] K_SKP = 8'h1C;
   localparam logic [7:0] K_FTS = 8'h3C;
   localparam logic [7:0] K_IDL = 8'h7C;
   localparam logic [7:0] D_SYM = 8'h4A;

   logic                clk = 1'b0;
   logic                rst;
   logic [NL*8-1:0]     sym_data;
   logic [NL-1:0]       sym_k, sym_valid, lane_mask;
   logic                clr;
   logic [NL-1:0]       skp_det, eios_det, fts_det, os_err, eios_seen;
   logic [NL*CNT_W-1:0] skp_cnt;
   logic                eios_all;

   int n_tests = 0;
   int n_fail  = 0;

   pcie_os_detect #(.NUM_LANES(NL), .MAX_SKP(MAX_SKP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .sym_data(sym_data), .sym_k(sym_k), .sym_valid(sym_valid),
      .lane_mask(lane_mask), .clr(clr), .skp_det(skp_det), .skp_cnt(skp_cnt),
      .eios_det(eios_det), .fts_det(fts_det), .os_err(os_err), .eios_seen(eios_seen),
      .eios_all(eios_all)
   );

   always #5 clk = ~clk;

   // Reference model: each lane keeps the list of symbol classes of the
   // ordered set collected so far, and judges it by its length and kind.
   typedef enum logic [2:0] {C_OTHER, C_COM, C_SKP, C_FTS, C_IDL} sym_cls_e;

   sym_cls_e            part [NL][10];
   int                  plen [NL];
   logic [NL-1:0]       exp_skp, exp_eios, exp_fts, exp_err, exp_seen;
   logic                exp_all;
   logic [NL*CNT_W-1:0] exp_cnt;

   function automatic sym_cls_e classify(input logic [7:0] d, input logic k);
      if (!k) return C_OTHER;
      case (d)
         K_COM:   return C_COM;
         K_SKP:   return C_SKP;
         K_FTS:   return C_FTS;
         K_IDL:   return C_IDL;
         default: return C_OTHER;
      endcase
   endfunction

   task automatic set_lane(input int l, input logic [7:0] d, input logic k, input logic v);
      sym_data[l*8 +: 8] = d;
      sym_k[l]           = k;
      sym_valid[l]       = v;
   endtask

   task automatic idle_all();
      for (int l = 0; l < NL; l++) set_lane(l, 8'h00, 1'b0, 1'b1);
   endtask

   // Advance one clock: predict the registered outputs from the current inputs.
   task automatic tick();
      logic [NL-1:0]       n_skp, n_eios, n_fts, n_err, n_seen;
      logic                n_all;
      logic [NL*CNT_W-1:0] n_cnt;
      sym_cls_e            s;
      logic                redo;
      n_skp = '0; n_eios = '0; n_fts = '0; n_err = '0;
      n_cnt = exp_cnt;
      if (rst) begin
         for (int l = 0; l < NL; l++) plen[l] = 0;
         n_seen = '0;
         n_all  = 1'b0;
         n_cnt  = '0;
      end else begin
         n_all  = (lane_mask != '0) && ((exp_seen & lane_mask) == lane_mask);
         n_seen = ((clr || n_all) ? '0 : exp_seen) | exp_eios;
         for (int l = 0; l < NL; l++) begin
            if (sym_valid[l]) begin
               s    = classify(sym_data[l*8 +: 8], sym_k[l]);
               redo = 1'b0;
               if (plen[l] == 0) begin
                  redo = 1'b1;
               end else if (plen[l] == 1) begin
                  if (s == C_SKP || s == C_IDL || s == C_FTS) begin
                     part[l][1] = s;
                     plen[l]    = 2;
                  end else begin
                     n_err[l] = 1'b1;
                     plen[l]  = 0;
                     redo     = 1'b1;
                  end
               end else if (part[l][1] == C_SKP) begin
                  if (s == C_SKP) begin
                     if (plen[l] - 1 < MAX_SKP) begin
                        part[l][plen[l]] = s;
                        plen[l]++;
                     end else begin
                        n_err[l] = 1'b1;
                        plen[l]  = 0;
                     end
                  end else begin
                     n_skp[l]                = 1'b1;
                     n_cnt[l*CNT_W +: CNT_W] = CNT_W'(plen[l] - 1);
                     plen[l]                 = 0;
                     redo                    = 1'b1;
                  end
               end else begin
                  if (s == part[l][1]) begin
                     part[l][plen[l]] = s;
                     plen[l]++;
                     if (plen[l] == 4) begin
                        n_eios[l] = (s == C_IDL);
                        n_fts[l]  = (s == C_FTS);
                        plen[l]   = 0;
                     end
                  end else begin
                     n_err[l] = 1'b1;
                     plen[l]  = 0;
                     redo     = 1'b1;
                  end
               end
               if (redo && s == C_COM) begin
                  part[l][0] = C_COM;
                  plen[l]    = 1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      exp_skp = n_skp; exp_eios = n_eios; exp_fts = n_fts; exp_err = n_err;
      exp_seen = n_seen; exp_all = n_all; exp_cnt = n_cnt;
   endtask

   task automatic drive1(input int l, input logic [7:0] d, input logic k);
      idle_all();
      set_lane(l, d, k, 1'b1);
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; lane_mask = 4'hF;
      idle_all();
      tick(); tick();
      rst = 1'b0;
      tick();
      n_tests += 7;
      if (skp_det !== '0)   begin n_fail++; $display("FAIL reset_skp_det got=%b exp=0", skp_det); end
      if (skp_cnt !== '0)   begin n_fail++; $display("FAIL reset_skp_cnt got=%h exp=0", skp_cnt); end
      if (eios_det !== '0)  begin n_fail++; $display("FAIL reset_eios_det got=%b exp=0", eios_det); end
      if (fts_det !== '0)   begin n_fail++; $display("FAIL reset_fts_det got=%b exp=0", fts_det); end
      if (os_err !== '0)    begin n_fail++; $display("FAIL reset_os_err got=%b exp=0", os_err); end
      if (eios_seen !== '0) begin n_fail++; $display("FAIL reset_eios_seen got=%b exp=0", eios_seen); end
      if (eios_all !== 1'b0) begin n_fail++; $display("FAIL reset_eios_all got=%b exp=0", eios_all); end
   endtask

   task automatic test_skp_com();
      drive1(0, K_COM, 1'b1);
      for (int j = 0; j < 3; j++) drive1(0, K_SKP, 1'b1);
      n_tests++;
      if (skp_det !== 4'b0000) begin n_fail++; $display("FAIL skp_early got=%b exp=0000", skp_det); end
      drive1(0, K_COM, 1'b1);
      n_tests += 2;
      if (skp_det !== 4'b0001)  begin n_fail++; $display("FAIL skp_det3 got=%b exp=0001", skp_det); end
      if (skp_cnt[2:0] !== 3'd3) begin n_fail++; $display("FAIL skp_cnt3 got=%0d exp=3", skp_cnt[2:0]); end
      // the terminating COM must already have opened the next OS
      drive1(0, K_SKP, 1'b1);
      drive1(0, K_COM, 1'b1);
      n_tests += 2;
      if (skp_det !== 4'b0001)  begin n_fail++; $display("FAIL skp_det1 got=%b exp=0001", skp_det); end
      if (skp_cnt[2:0] !== 3'd1) begin n_fail++; $display("FAIL skp_cnt1 got=%0d exp=1", skp_cnt[2:0]); end
      drive1(0, D_SYM, 1'b0);
      n_tests += 2;
      if (skp_det !== 4'b0000)  begin n_fail++; $display("FAIL skp_det_drop got=%b exp=0000", skp_det); end
      if (skp_cnt[2:0] !== 3'd1) begin n_fail++; $display("FAIL skp_cnt_hold got=%0d exp=1", skp_cnt[2:0]); end
   endtask

   task automatic test_skp_overflow();
      drive1(1, K_COM, 1'b1);
      for (int j = 1; j <= 6; j++) begin
         drive1(1, K_SKP, 1'b1);
         n_tests += 2;
         if (skp_det !== 4'b0000) begin n_fail++; $display("FAIL ovf_skp_det n=%0d got=%b exp=0000", j, skp_det); end
         if (os_err !== ((j == 6) ? 4'b0010 : 4'b0000)) begin
            n_fail++; $display("FAIL ovf_os_err n=%0d got=%b exp=%b", j, os_err, (j == 6) ? 4'b0010 : 4'b0000);
         end
      end
      drive1(1, D_SYM, 1'b0);
      n_tests += 2;
      if (skp_det !== 4'b0000) begin n_fail++; $display("FAIL ovf_after_skp got=%b exp=0000", skp_det); end
      if (os_err !== 4'b0000)  begin n_fail++; $display("FAIL ovf_after_err got=%b exp=0000", os_err); end
   endtask

   task automatic test_fts_err();
      drive1(2, K_COM, 1'b1);
      drive1(2, K_FTS, 1'b1);
      drive1(2, D_SYM, 1'b0);
      n_tests++;
      if (os_err !== 4'b0100) begin n_fail++; $display("FAIL fts_break_err got=%b exp=0100", os_err); end
      drive1(2, K_COM, 1'b1);
      n_tests++;
      if (os_err !== 4'b0000) begin n_fail++; $display("FAIL fts_com_err got=%b exp=0000", os_err); end
      for (int j = 1; j <= 3; j++) begin
         drive1(2, K_FTS, 1'b1);
         n_tests++;
         if (fts_det !== ((j == 3) ? 4'b0100 : 4'b0000)) begin
            n_fail++; $display("FAIL fts_det n=%0d got=%b exp=%b", j, fts_det, (j == 3) ? 4'b0100 : 4'b0000);
         end
      end
   endtask

   task automatic test_valid_gap();
      drive1(0, K_COM, 1'b1);
      drive1(0, K_IDL, 1'b1);
      for (int j = 0; j < 4; j++) begin
         idle_all();
         set_lane(0, K_IDL, 1'b1, 1'b0);
         tick();
         n_tests++;
         if ((skp_det | eios_det | fts_det | os_err) !== 4'b0000) begin
            n_fail++; $display("FAIL gap_pulses cyc=%0d got=%b exp=0000", j, skp_det | eios_det | fts_det | os_err);
         end
      end
      drive1(0, K_IDL, 1'b1);
      n_tests++;
      if (eios_det !== 4'b0000) begin n_fail++; $display("FAIL gap_early_eios got=%b exp=0000", eios_det); end
      drive1(0, K_IDL, 1'b1);
      n_tests++;
      if (eios_det !== 4'b0001) begin n_fail++; $display("FAIL gap_eios_det got=%b exp=0001", eios_det); end
      idle_all();
      tick();
      n_tests++;
      if (eios_seen[0] !== 1'b1) begin n_fail++; $display("FAIL gap_eios_seen got=%b exp=1", eios_seen[0]); end
   endtask

   task automatic test_eios_all();
      int lanes [3] = '{0, 1, 3};
      int skews [3] = '{0, 2, 5};
      int pulses = 0;
      lane_mask = 4'b1011;
      clr = 1'b1; idle_all(); tick(); clr = 1'b0;
      n_tests++;
      if (eios_seen !== 4'b0000) begin n_fail++; $display("FAIL all_clr got=%b exp=0000", eios_seen); end
      for (int t = 0; t <= 13; t++) begin
         idle_all();
         for (int j = 0; j < 3; j++) begin
            if (t == skews[j]) set_lane(lanes[j], K_COM, 1'b1, 1'b1);
            else if (t > skews[j] && t <= skews[j] + 3) set_lane(lanes[j], K_IDL, 1'b1, 1'b1);
         end
         tick();
         if (eios_all === 1'b1) pulses++;
         if (t == 8) begin
            n_tests++;
            if (eios_det !== 4'b1000) begin n_fail++; $display("FAIL all_det3 got=%b exp=1000", eios_det); end
         end
         if (t == 9) begin
            n_tests += 2;
            if (eios_seen !== 4'b1011) begin n_fail++; $display("FAIL all_seen got=%b exp=1011", eios_seen); end
            if (eios_all !== 1'b0) begin n_fail++; $display("FAIL all_early got=%b exp=0", eios_all); end
         end
         if (t == 10) begin
            n_tests += 2;
            if (eios_all !== 1'b1) begin n_fail++; $display("FAIL all_pulse got=%b exp=1", eios_all); end
            if (eios_seen !== 4'b0000) begin n_fail++; $display("FAIL all_seen_clear got=%b exp=0000", eios_seen); end
         end
      end
      n_tests++;
      if (pulses != 1) begin n_fail++; $display("FAIL all_count got=%0d exp=1", pulses); end
   endtask

   task automatic test_clr_set();
      clr = 1'b1; idle_all(); tick(); clr = 1'b0;
      n_tests++;
      if (eios_seen !== 4'b0000) begin n_fail++; $display("FAIL clr_plain got=%b exp=0000", eios_seen); end
      drive1(1, K_COM, 1'b1);
      for (int j = 0; j < 3; j++) drive1(1, K_IDL, 1'b1);
      n_tests++;
      if (eios_det !== 4'b0010) begin n_fail++; $display("FAIL clr_det got=%b exp=0010", eios_det); end
      clr = 1'b1; idle_all(); tick(); clr = 1'b0;
      n_tests++;
      if (eios_seen !== 4'b0010) begin n_fail++; $display("FAIL clr_set_wins got=%b exp=0010", eios_seen); end
   endtask

   task automatic test_mask();
      int pulses = 0;
      lane_mask = 4'b0000;
      for (int j = 0; j < 3; j++) begin
         idle_all(); tick();
         n_tests++;
         if (eios_all !== 1'b0) begin n_fail++; $display("FAIL mask0_all cyc=%0d got=%b exp=0", j, eios_all); end
      end
      lane_mask = 4'b0100;
      for (int t = 0; t <= 11; t++) begin
         idle_all();
         if (t == 0) set_lane(0, K_COM, 1'b1, 1'b1);
         else if (t <= 3) set_lane(0, K_IDL, 1'b1, 1'b1);
         else if (t == 4) set_lane(2, K_COM, 1'b1, 1'b1);
         else if (t <= 7) set_lane(2, K_IDL, 1'b1, 1'b1);
         tick();
         if (eios_all === 1'b1) pulses++;
         if (t == 5) begin
            n_tests++;
            if (eios_seen !== 4'b0011) begin n_fail++; $display("FAIL mask_unmasked_seen got=%b exp=0011", eios_seen); end
         end
         if (t == 8) begin
            n_tests++;
            if (eios_seen !== 4'b0111) begin n_fail++; $display("FAIL mask_seen got=%b exp=0111", eios_seen); end
         end
         if (t == 9) begin
            n_tests += 2;
            if (eios_all !== 1'b1) begin n_fail++; $display("FAIL mask_pulse got=%b exp=1", eios_all); end
            if (eios_seen !== 4'b0000) begin n_fail++; $display("FAIL mask_clear got=%b exp=0000", eios_seen); end
         end
      end
      n_tests++;
      if (pulses != 1) begin n_fail++; $display("FAIL mask_count got=%0d exp=1", pulses); end
   endtask

   task automatic test_reset_mid();
      drive1(0, K_COM, 1'b1);
      drive1(0, K_SKP, 1'b1);
      drive1(0, K_SKP, 1'b1);
      for (int j = 0; j < 3; j++) begin
         rst = (j == 0);
         if (j == 2) drive1(0, D_SYM, 1'b0);
         else drive1(0, K_SKP, 1'b1);
         n_tests += 3;
         if ((skp_det | eios_det | fts_det | os_err) !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_pulses cyc=%0d got=%b exp=0000", j, skp_det | eios_det | fts_det | os_err);
         end
         if (skp_cnt !== '0) begin n_fail++; $display("FAIL rstmid_cnt cyc=%0d got=%h exp=0", j, skp_cnt); end
         if ({eios_seen, eios_all} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_eios cyc=%0d got=%b exp=00000", j, {eios_seen, eios_all});
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] last_d [NL];
      logic       last_k [NL];
      for (int l = 0; l < NL; l++) begin last_d[l] = 8'h00; last_k[l] = 1'b0; end
      for (int c = 0; c < 4000; c++) begin
         if (c % 64 == 0) lane_mask = 4'($urandom_range(15, 0));
         rst = ($urandom_range(299, 0) == 0);
         clr = ($urandom_range(24, 0) == 0);
         for (int l = 0; l < NL; l++) begin
            if ($urandom_range(99, 0) >= 45) begin
               case ($urandom_range(5, 0))
                  0: begin last_d[l] = K_COM; last_k[l] = 1'b1; end
                  1: begin last_d[l] = K_SKP; last_k[l] = 1'b1; end
                  2: begin last_d[l] = K_IDL; last_k[l] = 1'b1; end
                  3: begin last_d[l] = K_FTS; last_k[l] = 1'b1; end
                  4: begin last_d[l] = 8'($urandom_range(255, 0)); last_k[l] = 1'b0; end
                  default: begin last_d[l] = 8'hF7; last_k[l] = 1'b1; end
               endcase
            end
            set_lane(l, last_d[l], last_k[l], $urandom_range(9, 0) != 0);
         end
         tick();
         n_tests += 7;
         if (skp_det !== exp_skp)   begin n_fail++; $display("FAIL rand_skp_det cyc=%0d got=%b exp=%b", c, skp_det, exp_skp); end
         if (skp_cnt !== exp_cnt)   begin n_fail++; $display("FAIL rand_skp_cnt cyc=%0d got=%h exp=%h", c, skp_cnt, exp_cnt); end
         if (eios_det !== exp_eios) begin n_fail++; $display("FAIL rand_eios_det cyc=%0d got=%b exp=%b", c, eios_det, exp_eios); end
         if (fts_det !== exp_fts)   begin n_fail++; $display("FAIL rand_fts_det cyc=%0d got=%b exp=%b", c, fts_det, exp_fts); end
         if (os_err !== exp_err)    begin n_fail++; $display("FAIL rand_os_err cyc=%0d got=%b exp=%b", c, os_err, exp_err); end
         if (eios_seen !== exp_seen) begin n_fail++; $display("FAIL rand_eios_seen cyc=%0d got=%b exp=%b", c, eios_seen, exp_seen); end
         if (eios_all !== exp_all)  begin n_fail++; $display("FAIL rand_eios_all cyc=%0d got=%b exp=%b", c, eios_all, exp_all); end
      end
      rst = 1'b0;
      clr = 1'b0;
   endtask

   initial begin
      for (int l = 0; l < NL; l++) plen[l] = 0;
      exp_skp = '0; exp_eios = '0; exp_fts = '0; exp_err = '0;
      exp_seen = '0; exp_all = 1'b0; exp_cnt = '0;
      rst = 1'b1; clr = 1'b0; lane_mask = '0;
      sym_data = '0; sym_k = '0; sym_valid = '0;
      test_reset();
      test_skp_com();
      test_skp_overflow();
      test_fts_err();
      test_valid_gap();
      test_eios_all();
      test_clr_set();
      test_mask();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
